// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and default sizing.
package arb_pkg;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT   = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT   = ST_GRANT,
    RELEASE = ST_RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or above the pointer, wrapping N-1 -> 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_onehot,
  output logic [IDW-1:0] o_idx
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_j;
  logic           w_found;

  // ptr < N and offset < N, so a single conditional subtract is enough for the modulo
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_j      = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, i_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(N))
        w_sum = w_sum - (IDW+1)'(N);
      w_j = w_sum[IDW-1:0];
      if (!w_found && i_req[w_j]) begin
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, owner-hold and bounded hold under contention.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int IDW      = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic [N-1:0]   i_req,
  output logic [N-1:0]   o_gnt,
  output logic           o_gnt_valid,
  output logic [IDW-1:0] o_gnt_id,
  output logic           o_preempt
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t     r_state;
  logic [IDW-1:0] r_ptr;
  logic [HW-1:0]  r_hold;
  logic [N-1:0]   r_gnt;
  logic           r_gnt_valid;
  logic [IDW-1:0] r_gnt_id;
  logic           r_preempt;

  logic [N-1:0]   w_pick_oh;
  logic [IDW-1:0] w_pick_idx;
  logic           w_owner_req;
  logic           w_others;
  logic           w_expired;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  assign w_owner_req = i_req[r_gnt_id];
  assign w_others    = |(i_req & ~r_gnt);
  assign w_expired   = (r_hold == HW'(MAX_HOLD-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_preempt   <= 1'b0;
    end else if (i_en) begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_gnt       <= w_pick_oh;
            r_gnt_id    <= w_pick_idx;
            r_gnt_valid <= 1'b1;
            r_hold      <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          // an owner drop wins over a coincident expiry, so no preempt pulse then
          if (!w_owner_req) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_state     <= RELEASE;
          end else if (!w_expired) begin
            r_hold <= r_hold + HW'(1);
          end else if (w_others) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b1;
            r_state     <= RELEASE;
          end
        end
        RELEASE: begin
          r_ptr   <= (r_gnt_id == IDW'(N-1)) ? '0 : r_gnt_id + IDW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=8) with hand-derived expectations.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_gnt_valid (gnt_valid),
    .o_gnt_id    (gnt_id),
    .o_preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic e_vld,
                         input logic [1:0] e_id, input logic e_pre);
    chk({tag, ".gnt"},     32'(gnt),       32'(e_gnt));
    chk({tag, ".valid"},   32'(gnt_valid), 32'(e_vld));
    chk({tag, ".id"},      32'(gnt_id),    32'(e_id));
    chk({tag, ".preempt"}, 32'(preempt),   32'(e_pre));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = 4'b1111;
    cyc(); cyc();
    chk_out("reset", 4'b0000, 0, 0, 0);
    chk("reset.ptr", 32'(dut.r_ptr), 0);
    rst = 1'b0;
    cyc();

    // full contention: 8-cycle tenures, preempt, then RELEASE + IDLE gap
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        chk_out("rot_hold", 4'(1 << k), 1, 2'(k), 0);
        cyc();
      end
      chk_out("rot_preempt", 4'b0000, 0, 2'(k), 1);
      cyc();
      chk_out("rot_gap", 4'b0000, 0, 2'(k), 0);
      chk("rot_ptr", 32'(dut.r_ptr), 32'((k + 1) % 4));
      cyc();
    end
    chk_out("rot_wrap", 4'b0001, 1, 0, 0);

    rst = 1'b1; req = 4'b0000;
    cyc();
    chk_out("rst_clear", 4'b0000, 0, 0, 0);
    rst = 1'b0;
    cyc();
    chk("idle_state", 32'(dut.r_state), 0);

    // voluntary release by requester 2
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk_out("vol_hold", 4'b0100, 1, 2, 0);
    end
    req = 4'b0000;
    cyc();
    chk_out("vol_drop", 4'b0000, 0, 2, 0);
    cyc();
    chk("vol_ptr", 32'(dut.r_ptr), 3);
    chk("vol_nopre", 32'(preempt), 0);
    req = 4'b1001;
    cyc();
    chk_out("vol_next", 4'b1000, 1, 3, 0);

    // owner 3 drops with 0 and 1 pending: wrap to requester 0
    req = 4'b0011;
    cyc();
    chk_out("wrap_rel", 4'b0000, 0, 3, 0);
    cyc();
    chk("wrap_ptr", 32'(dut.r_ptr), 0);
    cyc();
    chk_out("wrap_gnt", 4'b0001, 1, 0, 0);

    // owner drop on the expiry cycle is a plain release
    for (int c = 0; c < 7; c++) begin
      cyc();
      chk("coinc_hold.gnt", 32'(gnt), 32'(4'b0001));
    end
    req = 4'b0010;
    cyc();
    chk_out("coinc_rel", 4'b0000, 0, 0, 0);
    cyc();
    chk("coinc_ptr", 32'(dut.r_ptr), 1);
    cyc();

    // lone requester saturates the hold counter and keeps the grant
    chk_out("sat_start", 4'b0010, 1, 1, 0);
    for (int c = 0; c < 19; c++) begin
      cyc();
      chk_out("sat_hold", 4'b0010, 1, 1, 0);
    end
    chk("sat_cnt", 32'(dut.r_hold), 7);
    req = 4'b0011;
    cyc();
    chk_out("sat_preempt", 4'b0000, 0, 1, 1);
    cyc();
    chk("sat_ptr", 32'(dut.r_ptr), 2);
    chk("sat_pulse_end", 32'(preempt), 0);
    cyc();
    chk_out("sat_next", 4'b0001, 1, 0, 0);

    // clock enable freezes grant and hold counter
    cyc(); cyc();
    chk("en_cnt_before", 32'(dut.r_hold), 2);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk_out("en_freeze", 4'b0001, 1, 0, 0);
      chk("en_cnt_frozen", 32'(dut.r_hold), 2);
    end
    en = 1'b1;
    cyc();
    chk("en_cnt_after", 32'(dut.r_hold), 3);
    for (int c = 0; c < 4; c++) cyc();
    chk("en_cnt_top", 32'(dut.r_hold), 7);
    cyc();
    chk_out("en_preempt", 4'b0000, 0, 0, 1);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk_out("en_pre_held", 4'b0000, 0, 0, 1);
    end
    en = 1'b1;
    cyc();
    chk_out("en_pre_drop", 4'b0000, 0, 0, 0);
    cyc();
    chk_out("en_regrant", 4'b0010, 1, 1, 0);

    // synchronous reset mid-grant
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk_out("rst_mid", 4'b0000, 0, 0, 0);
    chk("rst_mid_ptr", 32'(dut.r_ptr), 0);
    chk("rst_mid_state", 32'(dut.r_state), 0);
    rst = 1'b0; req = 4'b0000;
    cyc();
    chk_out("rst_mid_idle", 4'b0000, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
